multi_port_fifo: RTL and testbench

MULTI_PORT_FIFO -- requirements
Module: multi_port_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/lead_ones_cnt.sv | 23 ++
 rtl/multi_port_fifo.sv | 99 +++++++++
 tb/tb_multi_port_fifo.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for multi_port_fifo.
// No ports; provides default parameter values and ptr_w().
package fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ENQ_N  = 2;
    localparam int DEF_DEQ_N  = 2;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lead_ones_cnt.sv
// lead_ones_cnt: length of the run of ones starting at bit 0.
// Ports: vec (N bits in), cnt ($clog2(N+1) bits out).
module lead_ones_cnt #(
    parameter int N = 2
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N+1)-1:0] cnt
);

    localparam int CW = $clog2(N + 1);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            run = run & vec[i];
            if (run) cnt = cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: circular FIFO with ENQ_N enqueue and DEQ_N
// dequeue lanes per cycle, zero read latency, no bypass.
// Ports: clk, rstn (sync active-low), enq_valid/enq_ready/enq_data,
// deq_valid/deq_ready/deq_data, count; flush only when
// MULTI_PORT_FIFO_FLUSH_EN is defined.
module multi_port_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ENQ_N  = DEF_ENQ_N,
    parameter int DEQ_N  = DEF_DEQ_N
) (
    input  logic                          clk,
    input  logic                          rstn,
`ifdef MULTI_PORT_FIFO_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic [ENQ_N-1:0]              enq_valid,
    output logic [ENQ_N-1:0]              enq_ready,
    input  logic [ENQ_N-1:0][DATA_W-1:0]  enq_data,
    output logic [DEQ_N-1:0]              deq_valid,
    input  logic [DEQ_N-1:0]              deq_ready,
    output logic [DEQ_N-1:0][DATA_W-1:0]  deq_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW  = ptr_w(DEPTH);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EKW = $clog2(ENQ_N + 1);
    localparam int DMW = $clog2(DEQ_N + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic [EKW-1:0]    enq_run;
    logic [DMW-1:0]    deq_run;
    logic [EKW-1:0]    enq_k;
    logic [DMW-1:0]    deq_m;

    logic [AW-1:0]     wr_idx [ENQ_N];

    assign count = CW'(tail - head);

    // Credit comes only from registered occupancy.
    for (genvar i = 0; i < ENQ_N; i++) begin : g_enq
        assign enq_ready[i] = (int'(count) + i) < DEPTH;
        assign wr_idx[i]    = AW'(tail + PW'(i));
    end

    for (genvar j = 0; j < DEQ_N; j++) begin : g_deq
        assign deq_valid[j] = int'(count) > j;
        assign deq_data[j]  = mem[AW'(head + PW'(j))];
    end

    lead_ones_cnt #(.N(ENQ_N)) u_enq_cnt (
        .vec (enq_valid & enq_ready),
        .cnt (enq_run)
    );

    lead_ones_cnt #(.N(DEQ_N)) u_deq_cnt (
        .vec (deq_valid & deq_ready),
        .cnt (deq_run)
    );

`ifdef MULTI_PORT_FIFO_FLUSH_EN
    assign enq_k = flush ? '0 : enq_run;
    assign deq_m = flush ? '0 : deq_run;
`else
    assign enq_k = enq_run;
    assign deq_m = deq_run;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
        end else begin
            tail <= tail + PW'(enq_k);
`ifdef MULTI_PORT_FIFO_FLUSH_EN
            // Flush empties by catching head up to tail.
            head <= flush ? tail : head + PW'(deq_m);
`else
            head <= head + PW'(deq_m);
`endif
        end
    end

    // Storage is not reset; only accepted lanes write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_N; i++) begin
            if (rstn && (i < int'(enq_k)))
                mem[wr_idx[i]] <= enq_data[i];
        end
    end

endmodule

// File: tb/tb_multi_port_fifo.sv
// tb_multi_port_fifo: randomized + directed bench for multi_port_fifo
// against a queue-based reference model.
module tb_multi_port_fifo;

    localparam int DEPTH = 8;

    logic            clk;
    logic            rstn;
`ifdef MULTI_PORT_FIFO_FLUSH_EN
    logic            flush;
`endif
    logic [1:0]      enq_valid;
    logic [1:0]      enq_ready;
    logic [1:0][31:0] enq_data;
    logic [1:0]      deq_valid;
    logic [1:0]      deq_ready;
    logic [1:0][31:0] deq_data;
    logic [3:0]      count;

    int n_pass;
    int n_total;

    logic [31:0] q[$];

    multi_port_fifo dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef MULTI_PORT_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lead(input logic [1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            if (v[i] && n == i) n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] m_enq_ready();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = (DEPTH - q.size()) > i;
        return r;
    endfunction

    function automatic logic [1:0] m_deq_valid();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = q.size() > i;
        return r;
    endfunction

    task automatic step(input logic [1:0] ev, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] dr);
        int k;
        int m;
        enq_valid   = ev;
        enq_data[0] = d0;
        enq_data[1] = d1;
        deq_ready   = dr;
        k = lead(ev & m_enq_ready());
        m = lead(dr & m_deq_valid());
        @(posedge clk);
        #1;
        if (!rstn) q.delete();
`ifdef MULTI_PORT_FIFO_FLUSH_EN
        else if (flush) q.delete();
`endif
        else begin
            repeat (m) void'(q.pop_front());
            if (k > 0) q.push_back(d0);
            if (k > 1) q.push_back(d1);
        end
        enq_valid = '0;
        deq_ready = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(2'b11, 32'hdead_0000, 32'hdead_0001, 2'b11);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (count !== 4'd0)
            $display("FAIL reset_count: got %0d want 0", count);
        else n_pass++;
        n_total++;
        if (deq_valid !== 2'b00)
            $display("FAIL reset_deq_valid: got %b want 00", deq_valid);
        else n_pass++;
        n_total++;
        if (enq_ready !== 2'b11)
            $display("FAIL reset_enq_ready: got %b want 11", enq_ready);
        else n_pass++;
        step(2'b11, 32'h1, 32'h2, 2'b00);
        step(2'b11, 32'h3, 32'h4, 2'b00);
        do_reset();
        n_total++;
        if (count !== 4'd0 || deq_valid !== 2'b00)
            $display("FAIL reset_midburst: got count=%0d dv=%b want 0/00",
                     count, deq_valid);
        else n_pass++;
    endtask

    task automatic test_pair_enq();
        do_reset();
        enq_valid = 2'b11;
        #1;
        n_total++;
        if (deq_valid !== 2'b00)
            $display("FAIL no_bypass: got dv=%b want 00", deq_valid);
        else n_pass++;
        step(2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'b00);
        n_total++;
        if (count !== 4'd2 || deq_valid !== 2'b11)
            $display("FAIL pair_state: got count=%0d dv=%b want 2/11",
                     count, deq_valid);
        else n_pass++;
        n_total++;
        if (deq_data[0] !== 32'hAAAA_AAAA || deq_data[1] !== 32'hBBBB_BBBB)
            $display("FAIL pair_data: got %h %h want aaaaaaaa bbbbbbbb",
                     deq_data[0], deq_data[1]);
        else n_pass++;
    endtask

    task automatic drain_check(input string tag);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            n_total++;
            if (deq_data[0] !== q[0])
                $display("FAIL %s_order: got %h want %h", tag, deq_data[0], q[0]);
            else n_pass++;
            step(2'b00, 32'h0, 32'h0, 2'b01);
            guard++;
        end
        n_total++;
        if (count !== 4'd0)
            $display("FAIL %s_drained: got count=%0d want 0", tag, count);
        else n_pass++;
    endtask

    task automatic test_near_full();
        do_reset();
        for (int i = 0; i < 3; i++)
            step(2'b11, 32'h100 + 2 * i, 32'h101 + 2 * i, 2'b00);
        step(2'b01, 32'h106, 32'h0, 2'b00);
        n_total++;
        if (count !== 4'd7 || enq_ready !== 2'b01)
            $display("FAIL near_full: got count=%0d er=%b want 7/01",
                     count, enq_ready);
        else n_pass++;
        step(2'b11, 32'h107, 32'h108, 2'b00);
        n_total++;
        if (count !== 4'd8 || enq_ready !== 2'b00)
            $display("FAIL full: got count=%0d er=%b want 8/00",
                     count, enq_ready);
        else n_pass++;
        drain_check("full");
    endtask

    task automatic test_lane_gap();
        do_reset();
        step(2'b10, 32'h55, 32'h66, 2'b00);
        n_total++;
        if (count !== 4'd0 || deq_valid !== 2'b00)
            $display("FAIL lane_gap: got count=%0d dv=%b want 0/00",
                     count, deq_valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b11, 32'h0, 32'h0, 2'b00);
        step(2'b01, 32'h0, 32'h0, 2'b00);
        for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 32'h0, 2'b11);
        step(2'b00, 32'h0, 32'h0, 2'b01);
        n_total++;
        if (count !== 4'd0)
            $display("FAIL wrap_pre: got count=%0d want 0", count);
        else n_pass++;
        step(2'b11, 32'hC0DE_0007, 32'hC0DE_0000, 2'b00);
        n_total++;
        if (dut.tail !== 4'd9)
            $display("FAIL wrap_tail: got %0d want 9", dut.tail);
        else n_pass++;
        n_total++;
        if (deq_data[0] !== 32'hC0DE_0007 || deq_data[1] !== 32'hC0DE_0000)
            $display("FAIL wrap_data: got %h %h want c0de0007 c0de0000",
                     deq_data[0], deq_data[1]);
        else n_pass++;
        step(2'b11, 32'hC0DE_0001, 32'hC0DE_0002, 2'b00);
        drain_check("wrap");
    endtask

    task automatic test_simul();
        do_reset();
        step(2'b11, 32'h11, 32'h22, 2'b00);
        step(2'b01, 32'h33, 32'h0, 2'b00);
        step(2'b11, 32'h44, 32'h55, 2'b11);
        n_total++;
        if (count !== 4'd3)
            $display("FAIL simul_count: got %0d want 3", count);
        else n_pass++;
        n_total++;
        if (deq_data[0] !== 32'h33 || deq_data[1] !== 32'h44)
            $display("FAIL simul_data: got %h %h want 33 44",
                     deq_data[0], deq_data[1]);
        else n_pass++;
        drain_check("simul");
    endtask

`ifdef MULTI_PORT_FIFO_FLUSH_EN
    task automatic test_flush();
        do_reset();
        step(2'b11, 32'h1, 32'h2, 2'b00);
        step(2'b11, 32'h3, 32'h4, 2'b00);
        step(2'b01, 32'h5, 32'h0, 2'b00);
        flush = 1'b1;
        step(2'b11, 32'h6, 32'h7, 2'b11);
        flush = 1'b0;
        n_total++;
        if (count !== 4'd0 || deq_valid !== 2'b00)
            $display("FAIL flush: got count=%0d dv=%b want 0/00",
                     count, deq_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [1:0] ev;
        logic [1:0] dr;
        logic [1:0] e_dv;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            e_dv = m_deq_valid();
            n_total++;
            if (count !== 4'(q.size()))
                $display("FAIL rnd_count c=%0d: got %0d want %0d",
                         c, count, q.size());
            else n_pass++;
            n_total++;
            if (enq_ready !== m_enq_ready() || deq_valid !== e_dv)
                $display("FAIL rnd_flags c=%0d: got er=%b dv=%b want %b %b",
                         c, enq_ready, deq_valid, m_enq_ready(), e_dv);
            else n_pass++;
            for (int j = 0; j < 2; j++) begin
                if (e_dv[j]) begin
                    n_total++;
                    if (deq_data[j] !== q[j])
                        $display("FAIL rnd_data c=%0d lane=%0d: got %h want %h",
                                 c, j, deq_data[j], q[j]);
                    else n_pass++;
                end
            end
            ev = 2'($urandom_range(0, 3));
            dr = 2'($urandom_range(0, 3));
            if (c > 200 && c < 260) dr = 2'b00;
            rstn = ($urandom_range(0, 99) != 0);
            step(ev, $urandom, $urandom, dr);
            rstn = 1'b1;
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rstn      = 1'b0;
`ifdef MULTI_PORT_FIFO_FLUSH_EN
        flush     = 1'b0;
`endif
        enq_valid = '0;
        enq_data  = '0;
        deq_ready = '0;
        test_reset();
        test_pair_enq();
        test_near_full();
        test_lane_gap();
        test_wrap();
        test_simul();
`ifdef MULTI_PORT_FIFO_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
